// File: rtl/sdram_burst_sched.sv
// Burst scheduler: shares one SDRAM ring-buffer region between a write stream and a read stream,
// issuing one burst at a time to the command arbiter over a req/ack/done handshake.
module sdram_burst_sched #(
  parameter int unsigned BURST_LEN    = 8,
  parameter logic [23:0] REGION_BASE  = 24'h000000,
  parameter logic [23:0] REGION_WORDS = 24'h001000,
  parameter int unsigned LVL_W        = 10
) (
  input  logic             sysclk_100M,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic [LVL_W-1:0] wr_fifo_lvl,
  input  logic [LVL_W-1:0] rd_fifo_free,
  output logic             burst_req,
  output logic             burst_we,
  output logic [1:0]       burst_bank,
  output logic [12:0]      burst_row,
  output logic [8:0]       burst_col,
  input  logic             burst_ack,
  input  logic             burst_done,
  output logic [23:0]      fill_words,
  output logic             ring_full,
  output logic             ring_empty
);

  localparam logic [23:0]      BURST_W    = 24'(BURST_LEN);
  localparam logic [LVL_W-1:0] BURST_LVL  = LVL_W'(BURST_LEN);
  localparam logic [23:0]      FULL_LIMIT = REGION_WORDS - BURST_W;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_BUSY} state_t;

  state_t      state_reg, state_next;
  logic        we_reg, we_next;
  logic [23:0] addr_reg, addr_next;
  logic [23:0] wr_ptr_reg, wr_ptr_next;
  logic [23:0] rd_ptr_reg, rd_ptr_next;
  logic [23:0] fill_reg, fill_next;
  logic        last_wr_reg, last_wr_next;  // 1 = previous grant went to the write stream
  logic        wr_ok, rd_ok, grant_wr;

  function automatic logic [23:0] advance(input logic [23:0] ptr);
    logic [23:0] sum;
    sum = ptr + BURST_W;
    return (sum == REGION_WORDS) ? 24'd0 : sum;
  endfunction

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      we_reg      <= 1'b0;
      addr_reg    <= 24'd0;
      wr_ptr_reg  <= 24'd0;
      rd_ptr_reg  <= 24'd0;
      fill_reg    <= 24'd0;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      fill_reg    <= fill_next;
      last_wr_reg <= last_wr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    fill_next    = fill_reg;
    last_wr_next = last_wr_reg;
    wr_ok    = (wr_fifo_lvl >= BURST_LVL) && !ring_full;
    rd_ok    = (rd_fifo_free >= BURST_LVL) && !ring_empty;
    // On a tie, hand the burst to the stream that did not get the last one
    grant_wr = wr_ok && (!rd_ok || !last_wr_reg);
    case (state_reg)
      S_IDLE: begin
        if (init_done) state_next = S_ARB;
      end
      S_ARB: begin
        if (wr_ok || rd_ok) begin
          state_next = S_REQ;
          we_next    = grant_wr;
          addr_next  = REGION_BASE + (grant_wr ? wr_ptr_reg : rd_ptr_reg);
        end
      end
      S_REQ: begin
        if (burst_ack) state_next = S_BUSY;
      end
      S_BUSY: begin
        if (burst_done) begin
          state_next   = S_ARB;
          last_wr_next = we_reg;
          if (we_reg) begin
            wr_ptr_next = advance(wr_ptr_reg);
            fill_next   = fill_reg + BURST_W;
          end else begin
            rd_ptr_next = advance(rd_ptr_reg);
            fill_next   = fill_reg - BURST_W;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign burst_req  = (state_reg == S_REQ);
  assign burst_we   = we_reg;
  assign burst_bank = addr_reg[23:22];
  assign burst_row  = addr_reg[21:9];
  assign burst_col  = addr_reg[8:0];
  assign fill_words = fill_reg;
  assign ring_full  = (fill_reg > FULL_LIMIT);
  assign ring_empty = (fill_reg < BURST_W);

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched: expected bursts are queued by the stimulus,
// a negedge monitor pops them when burst_req rises and checks them while it stays high.
module tb_sdram_burst_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_done;
  logic [9:0]  wr_lvl [2];
  logic [9:0]  rd_free [2];
  logic        req [2];
  logic        we [2];
  logic [1:0]  bank [2];
  logic [12:0] row [2];
  logic [8:0]  col [2];
  logic        ack [2];
  logic        done [2];
  logic [23:0] fill [2];
  logic        full [2];
  logic        empty [2];

  int vectors = 0;
  int miscompares = 0;
  logic [24:0] q0 [$];
  logic [24:0] q1 [$];

  sdram_burst_sched dut_a (
    .sysclk_100M(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_fifo_lvl(wr_lvl[0]), .rd_fifo_free(rd_free[0]),
    .burst_req(req[0]), .burst_we(we[0]), .burst_bank(bank[0]),
    .burst_row(row[0]), .burst_col(col[0]),
    .burst_ack(ack[0]), .burst_done(done[0]),
    .fill_words(fill[0]), .ring_full(full[0]), .ring_empty(empty[0])
  );

  sdram_burst_sched #(
    .BURST_LEN(8), .REGION_BASE(24'h0001F8), .REGION_WORDS(24'h000010), .LVL_W(10)
  ) dut_b (
    .sysclk_100M(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_fifo_lvl(wr_lvl[1]), .rd_fifo_free(rd_free[1]),
    .burst_req(req[1]), .burst_we(we[1]), .burst_bank(bank[1]),
    .burst_row(row[1]), .burst_col(col[1]),
    .burst_ack(ack[1]), .burst_done(done[1]),
    .fill_words(fill[1]), .ring_full(full[1]), .ring_empty(empty[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic w, input logic [23:0] a);
    if (d == 0) q0.push_back({w, a});
    else        q1.push_back({w, a});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int d);
    int t;
    t = 0;
    while (!req[d] && t < 60) begin
      cyc(1);
      t++;
    end
    chk($sformatf("req_seen_dut%0d", d), 32'(req[d]), 32'd1);
  endtask

  // Acts as the command arbiter for one burst; levels nw/nr are applied while the burst is busy
  task automatic do_burst(input int d, input int ack_dly, input bit spur,
                          input logic [9:0] nw, input logic [9:0] nr);
    wait_req(d);
    if (!req[d]) return;
    for (int i = 0; i < ack_dly; i++) begin
      done[d] = (spur && i == ack_dly / 2);
      cyc(1);
    end
    done[d] = spur;
    ack[d]  = 1'b1;
    cyc(1);
    ack[d]  = 1'b0;
    done[d] = 1'b0;
    chk($sformatf("req_dropped_dut%0d", d), 32'(req[d]), 32'd0);
    wr_lvl[d]  = nw;
    rd_free[d] = nr;
    cyc(2);
    done[d] = 1'b1;
    cyc(1);
    done[d] = 1'b0;
  endtask

  initial begin
    logic [24:0] cur [2];
    logic        prev [2];
    logic [24:0] got;
    cur[0] = '0; cur[1] = '0;
    prev[0] = 1'b0; prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = {we[d], bank[d], row[d], col[d]};
        if (req[d] && !prev[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_burst dut%0d: got %h expected none", d, got);
          end else if (d == 0) begin
            cur[0] = q0.pop_front();
          end else begin
            cur[1] = q1.pop_front();
          end
        end
        if (req[d]) chk($sformatf("burst_fields_dut%0d", d), 32'(got), 32'(cur[d]));
        prev[d] = req[d];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_lvl[d] = '0; rd_free[d] = '0; ack[d] = 1'b0; done[d] = 1'b0;
    end
    wr_lvl[0] = 10'd8;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_req", 32'(req[0]), 32'd0);
    chk("rst_we", 32'(we[0]), 32'd0);
    chk("rst_addr", 32'({bank[0], row[0], col[0]}), 32'd0);
    chk("rst_fill", 32'(fill[0]), 32'd0);
    chk("rst_empty", 32'(empty[0]), 32'd1);
    chk("rst_full", 32'(full[0]), 32'd0);
    chk("rst_empty_b", 32'(empty[1]), 32'd1);

    // First write burst after init: request two cycles after init_done
    cyc(2);
    push(0, 1'b1, 24'h000000);
    init_done = 1'b1;
    cyc(1);
    chk("req_before_latency", 32'(req[0]), 32'd0);
    cyc(1);
    chk("req_init_latency", 32'(req[0]), 32'd1);
    do_burst(0, 1, 1'b0, 10'd0, 10'd0);
    chk("fill_after_first", 32'(fill[0]), 32'd8);
    chk("empty_after_first", 32'(empty[0]), 32'd0);

    // Second write, then both streams eligible: reads and writes alternate
    push(0, 1'b1, 24'h000008);
    wr_lvl[0] = 10'd8;
    push(0, 1'b0, 24'h000000);
    push(0, 1'b1, 24'h000010);
    push(0, 1'b0, 24'h000008);
    push(0, 1'b1, 24'h000018);
    do_burst(0, 0, 1'b0, 10'd16, 10'd16);
    do_burst(0, 0, 1'b0, 10'd16, 10'd16);
    do_burst(0, 0, 1'b0, 10'd16, 10'd16);
    do_burst(0, 0, 1'b0, 10'd16, 10'd16);
    do_burst(0, 0, 1'b0, 10'd0, 10'd0);
    chk("fill_after_alternate", 32'(fill[0]), 32'd16);

    // Ack held off 20 cycles, with spurious done while requesting and together with ack
    push(0, 1'b1, 24'h000020);
    wr_lvl[0] = 10'd8;
    do_burst(0, 20, 1'b1, 10'd0, 10'd0);
    chk("fill_after_held_ack", 32'(fill[0]), 32'd24);

    // Small ring at base 0x1F8: second write crosses into row 1, then ring fills
    wr_lvl[1] = 10'd8;
    push(1, 1'b1, 24'h0001F8);
    push(1, 1'b1, 24'h000200);
    do_burst(1, 0, 1'b0, 10'd8, 10'd0);
    do_burst(1, 0, 1'b0, 10'd8, 10'd0);
    chk("ring_fill_b", 32'(fill[1]), 32'd16);
    chk("ring_full_b", 32'(full[1]), 32'd1);
    cyc(20);
    chk("write_blocked_when_full", 32'(req[1]), 32'd0);
    push(1, 1'b0, 24'h0001F8);
    push(1, 1'b1, 24'h0001F8);
    rd_free[1] = 10'd8;
    do_burst(1, 0, 1'b0, 10'd8, 10'd0);
    do_burst(1, 0, 1'b0, 10'd0, 10'd0);
    chk("fill_after_wrap_b", 32'(fill[1]), 32'd16);
    chk("full_after_wrap_b", 32'(full[1]), 32'd1);

    // Reset asserted while a burst is busy
    push(0, 1'b1, 24'h000028);
    wr_lvl[0] = 10'd8;
    wait_req(0);
    ack[0] = 1'b1;
    cyc(1);
    ack[0] = 1'b0;
    wr_lvl[0] = 10'd0;
    chk("we_while_busy", 32'(we[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(req[0]), 32'd0);
    chk("midrst_we", 32'(we[0]), 32'd0);
    chk("midrst_addr", 32'({bank[0], row[0], col[0]}), 32'd0);
    chk("midrst_fill", 32'(fill[0]), 32'd0);
    chk("midrst_empty", 32'(empty[0]), 32'd1);
    chk("midrst_full", 32'(full[0]), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    done[0] = 1'b1;
    cyc(1);
    done[0] = 1'b0;
    cyc(2);
    chk("fill_after_stray_done", 32'(fill[0]), 32'd0);
    chk("req_after_stray_done", 32'(req[0]), 32'd0);

    chk("queue_a_drained", 32'(q0.size()), 32'd0);
    chk("queue_b_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
